// File: rtl/bulls_cows_pkg.sv
// Shared types and helpers for the two-player Bulls & Cows engine.
// Imported by the interface, the code checker and the core.
package bulls_cows_pkg;

  typedef enum logic [2:0] {
    P1_SETUP = 3'd0,
    P2_SETUP = 3'd1,
    P1_GUESS = 3'd2,
    P2_GUESS = 3'd3,
    CHECK    = 3'd4,
    SCORE    = 3'd5,
    RESULT   = 3'd6,
    WIN      = 3'd7
  } state_t;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  // Widest code vector digit_of accepts; callers zero-extend into it.
  localparam int VEC_MAX_W = 256;

  function automatic logic [31:0] digit_of(input logic [VEC_MAX_W-1:0] vec,
                                           input int index,
                                           input int width);
    logic [VEC_MAX_W-1:0] shifted;
    logic [31:0]          mask;
    shifted = vec >> (index * width);
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return shifted[31:0] & mask;
  endfunction

endpackage

// File: rtl/bulls_cows_if.sv
// Entry/result bundle between the switch front end and the game core.
// The front end is the master, the core is the slave.
interface bulls_cows_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  import bulls_cows_pkg::*;

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                          confirm;
  logic [NUM_DIGITS*DIGIT_W-1:0] sw;
  state_t                        state_o;
  logic                          player_o;
  logic [CNT_W-1:0]              bulls_o;
  logic [CNT_W-1:0]              cows_o;
  logic                          result_valid_o;
  logic                          error_o;
  logic                          win_o;
  logic                          winner_o;

  modport master (
    output confirm, sw,
    input  state_o, player_o, bulls_o, cows_o,
           result_valid_o, error_o, win_o, winner_o
  );

  modport slave (
    input  confirm, sw,
    output state_o, player_o, bulls_o, cows_o,
           result_valid_o, error_o, win_o, winner_o
  );

endinterface

// File: rtl/bulls_cows_code_check.sv
// Combinational legality check of a code: all digits pairwise distinct and
// none above MAX_DIGIT. Also used by the display block for live feedback.
module bc_code_check
  import bulls_cows_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code_i,
  output logic                          distinct_ok_o,
  output logic                          range_ok_o
);

  logic [VEC_MAX_W-1:0] code_ext;

  assign code_ext = VEC_MAX_W'(code_i);

  always_comb begin
    distinct_ok_o = 1'b1;
    range_ok_o    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_of(code_ext, i, DIGIT_W) > 32'(MAX_DIGIT)) begin
        range_ok_o = 1'b0;
      end
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (digit_of(code_ext, i, DIGIT_W) == digit_of(code_ext, j, DIGIT_W)) begin
          distinct_ok_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bulls_cows_core.sv
// Two-player Bulls & Cows engine: captures secrets and guesses on confirm,
// validates them, scores one digit per cycle and alternates turns until a win.
//
// state    | meaning
// P1_SETUP | waiting for player 1 secret
// P2_SETUP | waiting for player 2 secret
// P1_GUESS | waiting for player 1 guess (against secret 2)
// P2_GUESS | waiting for player 2 guess (against secret 1)
// CHECK    | validating entry_q, dispatch by origin state
// SCORE    | one digit of entry_q scored per cycle
// RESULT   | bulls/cows presented, turn handed over or game won
// WIN      | game over, held until reset
module bulls_cows_core
  import bulls_cows_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGIT  = 9
) (
  input logic         clock,
  input logic         reset,
  bulls_cows_if.slave bus
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t             state_q;
  state_t             origin_q;
  logic [CODE_W-1:0]  entry_q;
  logic [CODE_W-1:0]  secret1_q;
  logic [CODE_W-1:0]  secret2_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   bulls_acc_q;
  logic [CNT_W-1:0]   cows_acc_q;
  logic               player_q;
  logic [CNT_W-1:0]   bulls_q;
  logic [CNT_W-1:0]   cows_q;
  logic               result_valid_q;
  logic               error_q;
  logic               win_q;
  logic               winner_q;

  logic               distinct_ok;
  logic               range_ok;
  logic [CODE_W-1:0]  target_d;
  logic [DIGIT_W-1:0] guess_dig_d;
  logic               bull_hit_d;
  logic               cow_hit_d;
  logic [CNT_W-1:0]   bulls_acc_d;
  logic [CNT_W-1:0]   cows_acc_d;

  bc_code_check #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .MAX_DIGIT  (MAX_DIGIT)
  ) u_code_check (
    .code_i        (entry_q),
    .distinct_ok_o (distinct_ok),
    .range_ok_o    (range_ok)
  );

  // Each player scores against the opponent's secret.
  always_comb begin
    target_d    = (player_q == PLAYER1) ? secret2_q : secret1_q;
    guess_dig_d = DIGIT_W'(digit_of(VEC_MAX_W'(entry_q), int'(idx_q), DIGIT_W));
    bull_hit_d  = (guess_dig_d ==
                   DIGIT_W'(digit_of(VEC_MAX_W'(target_d), int'(idx_q), DIGIT_W)));
    cow_hit_d   = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j != int'(idx_q)) &&
          (DIGIT_W'(digit_of(VEC_MAX_W'(target_d), j, DIGIT_W)) == guess_dig_d)) begin
        cow_hit_d = 1'b1;
      end
    end
    if (bull_hit_d) begin
      cow_hit_d = 1'b0;
    end
    bulls_acc_d = bulls_acc_q + CNT_W'(bull_hit_d);
    cows_acc_d  = cows_acc_q + CNT_W'(cow_hit_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= P1_SETUP;
      origin_q       <= P1_SETUP;
      entry_q        <= '0;
      secret1_q      <= '0;
      secret2_q      <= '0;
      idx_q          <= '0;
      bulls_acc_q    <= '0;
      cows_acc_q     <= '0;
      player_q       <= PLAYER1;
      bulls_q        <= '0;
      cows_q         <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      win_q          <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      case (state_q)
        P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: begin
          if (bus.confirm) begin
            entry_q  <= bus.sw;
            origin_q <= state_q;
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (!(distinct_ok && range_ok)) begin
            error_q <= 1'b1;
            state_q <= origin_q;
          end else begin
            case (origin_q)
              P1_SETUP: begin
                secret1_q <= entry_q;
                player_q  <= PLAYER2;
                state_q   <= P2_SETUP;
              end
              P2_SETUP: begin
                secret2_q <= entry_q;
                player_q  <= PLAYER1;
                state_q   <= P1_GUESS;
              end
              default: begin
                bulls_acc_q <= '0;
                cows_acc_q  <= '0;
                idx_q       <= '0;
                state_q     <= SCORE;
              end
            endcase
          end
        end
        SCORE: begin
          bulls_acc_q <= bulls_acc_d;
          cows_acc_q  <= cows_acc_d;
          // Outputs load on the last digit so they are stable during RESULT.
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            bulls_q        <= bulls_acc_d;
            cows_q         <= cows_acc_d;
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RESULT: begin
          if (bulls_acc_q == CNT_W'(NUM_DIGITS)) begin
            win_q    <= 1'b1;
            winner_q <= player_q;
            state_q  <= WIN;
          end else begin
            player_q <= ~player_q;
            state_q  <= (player_q == PLAYER1) ? P2_GUESS : P1_GUESS;
          end
        end
        WIN: begin
          state_q <= WIN;
        end
        default: begin
          state_q <= P1_SETUP;
        end
      endcase
    end
  end

  assign bus.state_o        = state_q;
  assign bus.player_o       = player_q;
  assign bus.bulls_o        = bulls_q;
  assign bus.cows_o         = cows_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.error_o        = error_q;
  assign bus.win_o          = win_q;
  assign bus.winner_o       = winner_q;

endmodule

// File: tb/tb_bulls_cows_core.sv
// Self-checking bench for bulls_cows_core: directed game plus randomized games
// checked against a digit-level reference model of the scoring rules.
module tb_bulls_cows_core;
  import bulls_cows_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int MAXD = 9;
  localparam int CW   = $clog2(N + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;

  bulls_cows_if #(.NUM_DIGITS(N), .DIGIT_W(DW)) bus ();

  bulls_cows_core #(.NUM_DIGITS(N), .DIGIT_W(DW), .MAX_DIGIT(MAXD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // ---------------- reference model ----------------
  function automatic int dig(input logic [N*DW-1:0] c, input int i);
    logic [N*DW-1:0] t;
    t = c >> (i * DW);
    return int'(t[DW-1:0]);
  endfunction

  function automatic logic [N*DW-1:0] set_dig(input logic [N*DW-1:0] c, input int i, input int v);
    logic [N*DW-1:0] m;
    logic [N*DW-1:0] val;
    m   = (N*DW)'((1 << DW) - 1) << (i * DW);
    val = (N*DW)'(v) << (i * DW);
    return (c & ~m) | (val & m);
  endfunction

  function automatic bit model_valid(input logic [N*DW-1:0] c);
    for (int i = 0; i < N; i++) begin
      if (dig(c, i) > MAXD) return 1'b0;
      for (int j = 0; j < i; j++) if (dig(c, i) == dig(c, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_score(input logic [N*DW-1:0] g, input logic [N*DW-1:0] t,
                                      output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (dig(g, i) == dig(t, i)) b++;
      else for (int j = 0; j < N; j++) if (dig(t, j) == dig(g, i)) c++;
    end
  endfunction

  function automatic logic [N*DW-1:0] rand_valid();
    int pool[MAXD+1];
    int k, tmp;
    logic [N*DW-1:0] c;
    for (int i = 0; i <= MAXD; i++) pool[i] = i;
    for (int i = MAXD; i > 0; i--) begin
      k = $urandom_range(0, i);
      tmp = pool[i]; pool[i] = pool[k]; pool[k] = tmp;
    end
    c = '0;
    for (int i = 0; i < N; i++) c = set_dig(c, i, pool[i]);
    return c;
  endfunction

  function automatic logic [N*DW-1:0] rand_invalid();
    logic [N*DW-1:0] c;
    int a, b;
    c = rand_valid();
    a = $urandom_range(0, N - 1);
    b = (a + 1 + $urandom_range(0, N - 2)) % N;
    if ($urandom_range(0, 1) == 1) c = set_dig(c, b, dig(c, a));
    else c = set_dig(c, a, $urandom_range(MAXD + 1, (1 << DW) - 1));
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [N*DW-1:0] code);
    bus.sw      = code;
    bus.confirm = 1'b1;
    cyc();
    bus.confirm = 1'b0;
  endtask

  task automatic do_reset();
    bus.confirm = 1'b0;
    bus.sw      = '0;
    reset       = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Confirms a guess and watches the result window; noise scrambles sw and
  // pulses confirm only while the engine must ignore them.
  task automatic run_guess(input logic [N*DW-1:0] code, input bit noise,
                           output int lat, output int nres, output int rb, output int rc);
    press(code);
    lat = -1; nres = 0; rb = -1; rc = -1;
    for (int t = 2; t <= N + 6; t++) begin
      if (noise && t <= N + 3) begin
        bus.sw      = (N*DW)'($urandom);
        bus.confirm = 1'($urandom_range(0, 1));
      end
      cyc();
      bus.confirm = 1'b0;
      if (bus.result_valid_o === 1'b1) begin
        if (nres == 0) begin
          lat = t;
          rb  = int'(bus.bulls_o);
          rc  = int'(bus.cows_o);
        end
        nres++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7+2*CW-1:0] obs;
    do_reset();
    vectors++;
    if (bus.state_o !== P1_SETUP) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_o, P1_SETUP);
    end
    obs = {bus.player_o, bus.bulls_o, bus.cows_o, bus.result_valid_o, bus.error_o,
           bus.win_o, bus.winner_o, 2'b00};
    vectors++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", obs);
    end
  endtask

  task automatic test_reject(input logic [N*DW-1:0] code, input state_t home);
    press(code);
    cyc();
    vectors++;
    if (bus.error_o !== 1'b1 || bus.state_o !== home) begin
      errors++; $display("FAIL reject_%h got err=%b st=%0d exp err=1 st=%0d",
                         code, bus.error_o, bus.state_o, home);
    end
    cyc();
    vectors++;
    if (bus.error_o !== 1'b0 || bus.state_o !== home) begin
      errors++; $display("FAIL reject_pulse_%h got err=%b st=%0d exp err=0 st=%0d",
                         code, bus.error_o, bus.state_o, home);
    end
  endtask

  task automatic test_setup();
    test_reject(16'h1123, P1_SETUP);
    test_reject(16'h12A4, P1_SETUP);
    for (int i = 0; i < 4; i++) test_reject(rand_invalid(), P1_SETUP);
    press(16'h1234);
    vectors++;
    if (bus.state_o !== CHECK) begin
      errors++; $display("FAIL setup_check got=%0d exp=%0d", bus.state_o, CHECK);
    end
    cyc();
    vectors++;
    if (bus.state_o !== P2_SETUP || bus.player_o !== 1'b1 || bus.error_o !== 1'b0) begin
      errors++; $display("FAIL setup_p1 got st=%0d pl=%b err=%b exp st=%0d pl=1 err=0",
                         bus.state_o, bus.player_o, bus.error_o, P2_SETUP);
    end
    test_reject(rand_invalid(), P2_SETUP);
    press(16'h5678);
    cyc();
    vectors++;
    if (bus.state_o !== P1_GUESS || bus.player_o !== 1'b0) begin
      errors++; $display("FAIL setup_p2 got st=%0d pl=%b exp st=%0d pl=0",
                         bus.state_o, bus.player_o, P1_GUESS);
    end
  endtask

  task automatic check_turn(input string tag, input int lat, input int nres, input int rb,
                            input int rc, input int eb, input int ec, input state_t est,
                            input logic epl);
    // Note: kept as a per-turn summary print; comparisons stay in callers.
    $display("turn %s lat=%0d n=%0d b=%0d c=%0d (exp b=%0d c=%0d st=%0d pl=%b)",
             tag, lat, nres, rb, rc, eb, ec, est, epl);
  endtask

  task automatic test_plan_game();
    int lat, nres, rb, rc;
    run_guess(16'h8765, 1'b0, lat, nres, rb, rc);
    vectors++;
    if (lat != N + 2 || nres != 1 || rb != 0 || rc != 4) begin
      errors++; $display("FAIL p1_guess got lat=%0d n=%0d b=%0d c=%0d exp lat=%0d n=1 b=0 c=4",
                         lat, nres, rb, rc, N + 2);
    end
    vectors++;
    if (bus.state_o !== P2_GUESS || bus.player_o !== 1'b1) begin
      errors++; $display("FAIL p1_next got st=%0d pl=%b exp st=%0d pl=1",
                         bus.state_o, bus.player_o, P2_GUESS);
    end
    run_guess(16'h1243, 1'b1, lat, nres, rb, rc);
    vectors++;
    if (lat != N + 2 || nres != 1 || rb != 2 || rc != 2) begin
      errors++; $display("FAIL p2_guess got lat=%0d n=%0d b=%0d c=%0d exp lat=%0d n=1 b=2 c=2",
                         lat, nres, rb, rc, N + 2);
    end
    vectors++;
    if (bus.state_o !== P1_GUESS || bus.player_o !== 1'b0) begin
      errors++; $display("FAIL p2_next got st=%0d pl=%b exp st=%0d pl=0",
                         bus.state_o, bus.player_o, P1_GUESS);
    end
    run_guess(16'h5678, 1'b0, lat, nres, rb, rc);
    vectors++;
    if (nres != 1 || rb != 4 || rc != 0) begin
      errors++; $display("FAIL p1_win_guess got n=%0d b=%0d c=%0d exp n=1 b=4 c=0", nres, rb, rc);
    end
    vectors++;
    if (bus.state_o !== WIN || bus.win_o !== 1'b1 || bus.winner_o !== 1'b0) begin
      errors++; $display("FAIL p1_win got st=%0d win=%b who=%b exp st=%0d win=1 who=0",
                         bus.state_o, bus.win_o, bus.winner_o, WIN);
    end
  endtask

  task automatic test_win_absorb();
    int events;
    events = 0;
    for (int i = 0; i < 6; i++) begin
      press((N*DW)'($urandom));
      if (bus.result_valid_o !== 1'b0 || bus.error_o !== 1'b0) events++;
      cyc();
      if (bus.result_valid_o !== 1'b0 || bus.error_o !== 1'b0) events++;
    end
    vectors++;
    if (bus.state_o !== WIN || bus.win_o !== 1'b1 || bus.winner_o !== 1'b0 || events != 0) begin
      errors++; $display("FAIL win_absorb got st=%0d win=%b who=%b ev=%0d exp st=%0d win=1 who=0 ev=0",
                         bus.state_o, bus.win_o, bus.winner_o, events, WIN);
    end
  endtask

  task automatic test_random_games();
    logic [N*DW-1:0] s1, s2, g, tgt;
    logic pl;
    int lat, nres, rb, rc, eb, ec;
    for (int game = 0; game < 6; game++) begin
      do_reset();
      s1 = rand_valid();
      s2 = rand_valid();
      press(s1); cyc();
      press(s2); cyc();
      vectors++;
      if (bus.state_o !== P1_GUESS) begin
        errors++; $display("FAIL rg_setup game=%0d got st=%0d exp=%0d", game, bus.state_o, P1_GUESS);
      end
      pl = 1'b0;
      for (int turn = 0; turn < 30; turn++) begin
        tgt = pl ? s1 : s2;
        case ($urandom_range(0, 9))
          0:       g = rand_invalid();
          1:       g = tgt;
          default: g = rand_valid();
        endcase
        if (!model_valid(g)) begin
          test_reject(g, pl ? P2_GUESS : P1_GUESS);
          continue;
        end
        model_score(g, tgt, eb, ec);
        run_guess(g, 1'($urandom_range(0, 1)), lat, nres, rb, rc);
        vectors++;
        if (lat != N + 2 || nres != 1 || rb != eb || rc != ec) begin
          errors++; $display("FAIL rg_score g=%h got lat=%0d n=%0d b=%0d c=%0d exp lat=%0d n=1 b=%0d c=%0d",
                             g, lat, nres, rb, rc, N + 2, eb, ec);
        end
        if (eb == N) begin
          vectors++;
          if (bus.state_o !== WIN || bus.win_o !== 1'b1 || bus.winner_o !== pl) begin
            errors++; $display("FAIL rg_win got st=%0d win=%b who=%b exp st=%0d win=1 who=%b",
                               bus.state_o, bus.win_o, bus.winner_o, WIN, pl);
          end
          break;
        end
        pl = ~pl;
        vectors++;
        if (bus.state_o !== (pl ? P2_GUESS : P1_GUESS) || bus.player_o !== pl) begin
          errors++; $display("FAIL rg_turn got st=%0d pl=%b exp pl=%b", bus.state_o, bus.player_o, pl);
        end
      end
    end
  endtask

  task automatic test_reset_mid_score();
    logic [6+2*CW-1:0] obs;
    int lat, nres, rb, rc;
    do_reset();
    press(16'h1234); cyc();
    press(16'h5678); cyc();
    press(16'h8765);
    cyc();
    cyc();
    vectors++;
    if (bus.state_o !== SCORE) begin
      errors++; $display("FAIL mid_score_reach got=%0d exp=%0d", bus.state_o, SCORE);
    end
    reset = 1'b1;
    #1;
    obs = {bus.player_o, bus.bulls_o, bus.cows_o, bus.result_valid_o, bus.error_o,
           bus.win_o, bus.winner_o, 1'b0};
    vectors++;
    if (bus.state_o !== P1_SETUP || obs !== '0) begin
      errors++; $display("FAIL async_reset got st=%0d outs=%h exp st=0 outs=0", bus.state_o, obs);
    end
    cyc();
    reset = 1'b0;
    cyc();
    press(16'h9012);
    cyc();
    vectors++;
    if (bus.state_o !== P2_SETUP || bus.player_o !== 1'b1 || bus.error_o !== 1'b0) begin
      errors++; $display("FAIL new_secret got st=%0d pl=%b err=%b exp st=%0d pl=1 err=0",
                         bus.state_o, bus.player_o, bus.error_o, P2_SETUP);
    end
    press(16'h3456); cyc();
    run_guess(16'h6543, 1'b0, lat, nres, rb, rc);
    run_guess(16'h9012, 1'b0, lat, nres, rb, rc);
    vectors++;
    if (rb != 4 || bus.state_o !== WIN || bus.winner_o !== 1'b1) begin
      errors++; $display("FAIL p2_win got b=%0d st=%0d who=%b exp b=4 st=%0d who=1",
                         rb, bus.state_o, bus.winner_o, WIN);
    end
  endtask

  initial begin
    bus.confirm = 1'b0;
    bus.sw      = '0;
    test_reset();
    test_setup();
    test_plan_game();
    test_win_absorb();
    test_random_games();
    test_reset_mid_score();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
